iomem_initiator: RTL and testbench
==================================

// Module: iomem_initiator
// PURPOSE
//  Bus master (initiator) for the PicoSoC iomem protocol. It is the opposite end from the
//  iomem peripherals such as the system clock counter. It takes single read/write commands
//  on a valid/ready command port and performs one iomem transaction per command. It then
//  returns read data, or a timeout flag, on a valid/ready response port.
//  Purpose: lets non-CPU logic (e.g. a LinuxCNC-RIO host-interface engine) access iomem peripherals.
// PARAMETERS
//  TIMEOUT   1024  max cycles iomem_valid stays high without iomem_ready; 0 = wait forever
//  TO_CNT_W  16    width of the saturating timeout-event counter
// PORTS
//  clk            in   1   single system clock; everything is on its rising edge
//  reset          in   1   synchronous, active-high reset
//  cmd_valid      in   1   command present
//  cmd_ready      out  1   command accepted when cmd_valid && cmd_ready
//  cmd_addr       in   32  target iomem address
//  cmd_wdata      in   32  write data
//  cmd_wstrb      in   4   byte strobes; 4'b0000 = read
//  rsp_valid      out  1   response present; held until rsp_ready
//  rsp_ready      in   1   response consumed when rsp_valid && rsp_ready
//  rsp_rdata      out  32  captured iomem_rdata (0 on timeout)
//  rsp_timeout    out  1   transaction aborted by timeout
//  iomem_valid    out  1   bus request
//  iomem_ready    in   1   responder completion (registered, one-cycle pulse)
//  iomem_addr     out  32  bus address
//  iomem_wdata    out  32  bus write data
//  iomem_wstrb    out  4   bus byte strobes
//  iomem_rdata    in   32  bus read data, valid when iomem_ready=1
//  busy           out  1   state != IDLE
//  timeout_count  out  TO_CNT_W  number of timeouts, saturates at all-ones
// BEHAVIOUR
//  - Reset: state=IDLE, iomem_valid=0, rsp_valid=0, rsp_timeout=0, rsp_rdata=0.
//    iomem_addr/wdata/wstrb=0, timeout_count=0, internal wait counter=0.
//  - All outputs are registered, except cmd_ready = (state==IDLE) and busy = (state!=IDLE), both decoded from the state register.
//  - FSM:
//    - IDLE: on cmd_valid, latch addr/wdata/wstrb onto the iomem_* outputs, set iomem_valid=1, clear the wait counter, go to BUS.
//    - BUS: iomem_addr/wdata/wstrb are held stable.
//      - If iomem_ready=1: rsp_rdata<=iomem_rdata, rsp_timeout<=0, iomem_valid<=0, rsp_valid<=1, go to RESP.
//      - Else, if TIMEOUT!=0 and the wait counter == TIMEOUT-1: iomem_valid<=0, rsp_rdata<=0, rsp_timeout<=1, rsp_valid<=1, timeout_count += 1 (saturating), go to RESP.
//      - Else: increment the wait counter.
//      - If iomem_ready and timeout occur in the same cycle, ready wins: normal completion, no count.
//    - RESP: hold rsp_* until rsp_ready=1. Then rsp_valid<=0 and go to IDLE.
//      A new command is accepted at the earliest on the cycle after the handshake.
//  - For writes, rsp_rdata holds whatever iomem_rdata showed at ready (don't-care).
//    The response still indicates completion.
//  - iomem_valid drops on the cycle after iomem_ready is sampled high. This is required:
//    responders re-trigger on (valid && !ready), so valid must never stay high past the ready pulse.
//  - Latency with a single-cycle responder: command accepted at cycle T, iomem_valid=1 at T+1, iomem_ready at T+2, rsp_valid=1 at T+3.
//  - Throughput: at most one outstanding transaction; no pipelining.
//  - iomem_ready seen outside BUS is ignored.
//  - Reset mid-transaction: iomem_valid and rsp_valid are 0 on the next cycle. No response is produced for the aborted command.
//  - Wait counter is wide enough for TIMEOUT-1; it never wraps while in BUS.
// TESTING
//  1. Read from addr 0x0200_0000: model returns 0x1234_5678 with ready 1 cycle after valid
//     -> rsp_valid at T+3, rsp_rdata=0x1234_5678, rsp_timeout=0, iomem_valid high for exactly 2 cycles.
//  2. Write 0xA5A5_A5A5 with wstrb=4'b0101: model records byte lanes
//     -> only bytes 0 and 2 updated; iomem_wstrb=4'b0101 stable while valid.
//  3. TIMEOUT=8, responder silent -> iomem_valid high for exactly 8 cycles, rsp_timeout=1, rsp_rdata=0, timeout_count=1.
//  4. Hold rsp_ready=0 for 5 cycles with cmd_valid asserted -> cmd_ready=0 throughout, rsp_* stable. Next command is accepted the cycle after rsp_ready.
//  5. Ready arrives on the exact timeout cycle (TIMEOUT=4, ready at wait count 3) -> normal response, timeout_count unchanged.
//  6. Assert reset while in BUS -> next cycle iomem_valid=0, busy=0, no rsp_valid. Then a fresh read completes normally.

Source files
------------

// File: rtl/iomem_initiator.sv
// Single-outstanding iomem bus master: valid/ready command in, one iomem transaction,
// valid/ready response out with optional timeout abort and a saturating timeout counter.
module iomem_initiator #(
  parameter int TIMEOUT  = 1024,
  parameter int TO_CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [31:0]         cmd_addr,
  input  logic [31:0]         cmd_wdata,
  input  logic [3:0]          cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_timeout,
  output logic                iomem_valid,
  input  logic                iomem_ready,
  output logic [31:0]         iomem_addr,
  output logic [31:0]         iomem_wdata,
  output logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_rdata,
  output logic                busy,
  output logic [TO_CNT_W-1:0] timeout_count
);

  // Wait counter only has to reach TIMEOUT-1, so it never wraps while waiting.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      iomem_valid   <= 1'b0;
      iomem_addr    <= '0;
      iomem_wdata   <= '0;
      iomem_wstrb   <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_timeout   <= 1'b0;
      timeout_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            iomem_addr  <= cmd_addr;
            iomem_wdata <= cmd_wdata;
            iomem_wstrb <= cmd_wstrb;
            iomem_valid <= 1'b1;
            wait_cnt    <= '0;
            state       <= BUS;
          end
        end
        BUS: begin
          // Ready has priority over a timeout landing on the same cycle.
          if (iomem_ready) begin
            iomem_valid <= 1'b0;
            rsp_rdata   <= iomem_rdata;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
            iomem_valid <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            if (timeout_count != '1) begin
              timeout_count <= timeout_count + 1'b1;
            end
            state       <= RESP;
          end else if (TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_initiator.sv
// Directed bench for iomem_initiator: a one-cycle iomem responder model drives the main
// instance (TIMEOUT=8); a second instance (TIMEOUT=4) is hand-driven for the ready/timeout race.
module tb_iomem_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] cmd_addr, cmd_wdata, rsp_rdata;
  logic [3:0]  cmd_wstrb;
  logic        iomem_valid, iomem_ready, busy;
  logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
  logic [3:0]  iomem_wstrb;
  logic [15:0] timeout_count;

  logic        c4_cmd_valid, c4_cmd_ready, c4_rsp_valid, c4_rsp_ready, c4_rsp_timeout;
  logic [31:0] c4_rsp_rdata, c4_iomem_addr, c4_iomem_wdata, c4_iomem_rdata;
  logic [3:0]  c4_iomem_wstrb;
  logic        c4_iomem_valid, c4_iomem_ready, c4_busy;
  logic [15:0] c4_timeout_count;

  logic        resp_en;
  logic [31:0] mem [4];
  int          checks = 0;
  int          errors = 0;
  int          vcyc;

  always #5 clk = ~clk;

  iomem_initiator #(.TIMEOUT(8), .TO_CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_wstrb(iomem_wstrb), .iomem_rdata(iomem_rdata),
    .busy(busy), .timeout_count(timeout_count)
  );

  iomem_initiator #(.TIMEOUT(4), .TO_CNT_W(16)) dut4 (
    .clk(clk), .reset(reset),
    .cmd_valid(c4_cmd_valid), .cmd_ready(c4_cmd_ready), .cmd_addr(32'h0300_0000),
    .cmd_wdata(32'h0), .cmd_wstrb(4'b0000),
    .rsp_valid(c4_rsp_valid), .rsp_ready(c4_rsp_ready), .rsp_rdata(c4_rsp_rdata),
    .rsp_timeout(c4_rsp_timeout),
    .iomem_valid(c4_iomem_valid), .iomem_ready(c4_iomem_ready), .iomem_addr(c4_iomem_addr),
    .iomem_wdata(c4_iomem_wdata), .iomem_wstrb(c4_iomem_wstrb), .iomem_rdata(c4_iomem_rdata),
    .busy(c4_busy), .timeout_count(c4_timeout_count)
  );

  // Registered responder: one-cycle ready pulse on (valid && !ready), byte-lane writes.
  always @(posedge clk) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'hDEAD_BEEF;
      mem[0] <= 32'h1234_5678;
      mem[1] <= 32'h1122_3344;
      mem[2] <= 32'h0;
      mem[3] <= 32'h0;
    end else if (resp_en && iomem_valid && !iomem_ready) begin
      iomem_ready <= 1'b1;
      iomem_rdata <= mem[iomem_addr[3:2]];
      for (int b = 0; b < 4; b++)
        if (iomem_wstrb[b]) mem[iomem_addr[3:2]][b*8 +: 8] <= iomem_wdata[b*8 +: 8];
    end else begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'hDEAD_BEEF;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    cmd_valid = 1'b1;
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    $display("cmd %s addr=0x%08h wdata=0x%08h wstrb=%b", tag, a, d, s);
  endtask

  // Counts iomem_valid-high cycles until rsp_valid, bounded.
  task automatic wait_rsp(input string tag, output int vc);
    int n = 0;
    vc = 0;
    while (!rsp_valid && n < 40) begin
      if (iomem_valid) vc++;
      step();
      n++;
    end
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic ack(input string tag);
    $display("rsp %s rdata=0x%08h timeout=%0b", tag, rsp_rdata, rsp_timeout);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; resp_en = 1'b1;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    c4_cmd_valid = 1'b0; c4_rsp_ready = 1'b0; c4_iomem_ready = 1'b0; c4_iomem_rdata = 32'h0;
    step();
    step();
    chk("reset iomem_valid", 32'(iomem_valid), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("reset iomem_addr", iomem_addr, 32'd0);
    chk("reset timeout_count", 32'(timeout_count), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();
    chk("idle cmd_ready", 32'(cmd_ready), 32'd1);

    // 1: read latency with single-cycle responder
    issue("rd0", 32'h0200_0000, 32'h0, 4'b0000);
    chk("rd0 T+1 iomem_valid", 32'(iomem_valid), 32'd1);
    chk("rd0 T+1 iomem_addr", iomem_addr, 32'h0200_0000);
    chk("rd0 T+1 cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    chk("rd0 T+2 iomem_valid", 32'(iomem_valid), 32'd1);
    chk("rd0 T+2 rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("rd0 T+3 rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd0 T+3 iomem_valid", 32'(iomem_valid), 32'd0);
    chk("rd0 rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("rd0 rsp_timeout", 32'(rsp_timeout), 32'd0);
    ack("rd0");

    // 2: partial write, lanes 0 and 2
    issue("wr1", 32'h0200_0004, 32'hA5A5_A5A5, 4'b0101);
    chk("wr1 T+1 wstrb", 32'(iomem_wstrb), 32'h5);
    chk("wr1 T+1 wdata", iomem_wdata, 32'hA5A5_A5A5);
    step();
    chk("wr1 T+2 wstrb", 32'(iomem_wstrb), 32'h5);
    chk("wr1 T+2 iomem_valid", 32'(iomem_valid), 32'd1);
    step();
    chk("wr1 rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr1 rsp_timeout", 32'(rsp_timeout), 32'd0);
    ack("wr1");
    chk("wr1 mem lanes", mem[1], 32'h11A5_33A5);
    issue("rd1", 32'h0200_0004, 32'h0, 4'b0000);
    wait_rsp("rd1", vcyc);
    chk("rd1 rsp_rdata", rsp_rdata, 32'h11A5_33A5);
    ack("rd1");

    // 3: silent responder, TIMEOUT=8
    resp_en = 1'b0;
    issue("to2", 32'h0200_0008, 32'h0, 4'b0000);
    wait_rsp("to2", vcyc);
    chk("to2 valid cycles", 32'(vcyc), 32'd8);
    chk("to2 rsp_timeout", 32'(rsp_timeout), 32'd1);
    chk("to2 rsp_rdata", rsp_rdata, 32'd0);
    chk("to2 timeout_count", 32'(timeout_count), 32'd1);

    // 4: back-pressure on the response while a new command waits
    resp_en = 1'b1;
    cmd_addr = 32'h0200_0000; cmd_wdata = 32'h0; cmd_wstrb = 4'b0000; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp rsp_timeout", 32'(rsp_timeout), 32'd1);
      chk("bp rsp_rdata", rsp_rdata, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    chk("bp hs cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    rsp_ready = 1'b0;
    chk("bp after rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp after cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("bp accept iomem_valid", 32'(iomem_valid), 32'd1);
    wait_rsp("rd3", vcyc);
    chk("rd3 rsp_rdata", rsp_rdata, 32'h1234_5678);
    ack("rd3");

    // 5: ready on the exact timeout cycle (TIMEOUT=4, wait count 3)
    c4_cmd_valid = 1'b1;
    step();
    c4_cmd_valid = 1'b0;
    step();
    step();
    step();
    chk("race iomem_valid", 32'(c4_iomem_valid), 32'd1);
    c4_iomem_ready = 1'b1;
    c4_iomem_rdata = 32'hCAFE_F00D;
    step();
    c4_iomem_ready = 1'b0;
    c4_iomem_rdata = 32'h0;
    chk("race rsp_valid", 32'(c4_rsp_valid), 32'd1);
    chk("race rsp_timeout", 32'(c4_rsp_timeout), 32'd0);
    chk("race rsp_rdata", c4_rsp_rdata, 32'hCAFE_F00D);
    chk("race timeout_count", 32'(c4_timeout_count), 32'd0);
    $display("rsp race rdata=0x%08h timeout=%0b", c4_rsp_rdata, c4_rsp_timeout);
    c4_rsp_ready = 1'b1;
    step();
    c4_rsp_ready = 1'b0;

    // 6: reset while in BUS
    resp_en = 1'b0;
    issue("ab4", 32'h0200_0000, 32'h0, 4'b0000);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort iomem_valid", 32'(iomem_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 10; i++) step();
    chk("abort no rsp", 32'(rsp_valid), 32'd0);
    resp_en = 1'b1;
    issue("rd5", 32'h0200_0000, 32'h0, 4'b0000);
    wait_rsp("rd5", vcyc);
    chk("rd5 valid cycles", 32'(vcyc), 32'd2);
    chk("rd5 rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("rd5 rsp_timeout", 32'(rsp_timeout), 32'd0);
    ack("rd5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
